// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned LaneW     = 8;
    localparam int unsigned WordBytes = 4;
    localparam int unsigned CntW      = 4;

    // Misaligned, or beyond the last word of an idx_w-bit word index.
    function automatic logic addr_err(logic [31:0] addr, int unsigned idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response handshakes between the core and the responder.
interface dmem_if;
    import dmem_pkg::*;

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [31:0]                  req_addr;
    logic [WordBytes*LaneW-1:0]   req_wdata;
    logic [WordBytes-1:0]         req_be;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [WordBytes*LaneW-1:0]   rsp_rdata;
    logic                         rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Byte-lane writable word RAM: synchronous write, combinational word read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned Depth    = 256,
    parameter string       InitFile = "",
    localparam int unsigned IdxW    = $clog2(Depth)
) (
    input  logic                       clk_i,
    input  logic [WordBytes-1:0]       we_i,
    input  logic [IdxW-1:0]            idx_i,
    input  logic [WordBytes*LaneW-1:0] wdata_i,
    output logic [WordBytes*LaneW-1:0] rdata_o
);

    logic [WordBytes-1:0][LaneW-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WordBytes; i++) begin
            if (we_i[i]) begin
                mem[idx_i][i] <= wdata_i[i*LaneW +: LaneW];
            end
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to flag misaligned / out-of-range accesses with rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int unsigned     IdxW    = $clog2(DEPTH_WORDS);
    localparam int unsigned     DataW   = WordBytes * LaneW;
    localparam logic [CntW-1:0] CntLoad = CntW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DataW-1:0]     wdata_q, wdata_d;
    logic [WordBytes-1:0] be_q, be_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 accept, commit, req_err;
    logic                 c_we, c_err;
    logic [IdxW-1:0]      c_idx;
    logic [DataW-1:0]     c_wdata, mem_rdata;
    logic [WordBytes-1:0] c_be, mem_we;
    logic                 unused_addr;

    assign unused_addr = ^bus.req_addr;

`ifdef DMEM_ERR_EN
    assign req_err = addr_err(bus.req_addr, IdxW);
`else
    assign req_err = 1'b0;
`endif

    // With no wait states the commit happens on the acceptance edge, straight from the bus.
    always_comb begin
        bus.req_ready = (state_q == StIdle);
        accept        = bus.req_valid && (state_q == StIdle);
        if (state_q == StIdle) begin
            c_we    = bus.req_we;
            c_err   = req_err;
            c_idx   = bus.req_addr[IdxW+1:2];
            c_wdata = bus.req_wdata;
            c_be    = bus.req_be;
        end else begin
            c_we    = we_q;
            c_err   = err_q;
            c_idx   = idx_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
        commit = rst && ((accept && (WAIT_CYCLES == 0)) || ((state_q == StWait) && (cnt_q == '0)));
        mem_we = (commit && c_we && !c_err) ? c_be : '0;
    end

    dmem_array #(
        .Depth    (DEPTH_WORDS),
        .InitFile (INIT_FILE)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (c_idx),
        .wdata_i (c_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    err_d   = req_err;
                    idx_d   = bus.req_addr[IdxW+1:2];
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (c_we || c_err) ? '0 : mem_rdata;
            rsp_err_d   = c_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 0, 1, 3) against a word/byte memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst0, rst1, rst3;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [3][256];
    virtual dmem_if vifs [3];

    always #5 clk = ~clk;

    dmem_if bus0 ();
    dmem_if bus1 ();
    dmem_if bus3 ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk (clk), .rst (rst0), .bus (bus0)
    );
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .INIT_FILE("")) u_dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    function automatic int wc_of(int inst);
        return (inst == 0) ? 0 : (inst == 1) ? 1 : 3;
    endfunction

    function automatic logic model_err(logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a % 4 != 0) || (a >= 32'd1024);
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // Word index is the byte address divided by four, modulo the 256-word depth.
    task automatic model_access(input int inst, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] exp_rd, output logic exp_err);
        int          idx;
        logic [31:0] w;
        exp_err = model_err(a);
        exp_rd  = 32'd0;
        idx     = int'((a / 4) % 256);
        if (!exp_err) begin
            if (we) begin
                w = ref_mem[inst][idx];
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                end
                ref_mem[inst][idx] = w;
            end else begin
                exp_rd = ref_mem[inst][idx];
            end
        end
    endtask

    // One full transaction; latency counts edges from acceptance to the edge that sees rsp_valid.
    task automatic txn(input virtual dmem_if v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output int lat, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        while (v.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        v.req_valid = 1'b1;
        v.req_we    = we;
        v.req_addr  = a;
        v.req_wdata = wd;
        v.req_be    = be;
        v.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        v.req_valid = 1'b0;
        v.req_we    = 1'($urandom());
        v.req_addr  = $urandom();
        v.req_wdata = $urandom();
        v.req_be    = 4'($urandom());
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (v.rsp_valid !== 1'b1 && lat < 40);
        rd = v.rsp_rdata;
        er = v.rsp_err;
        v.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        v.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vifs[i].req_valid = 1'b0;
            vifs[i].req_we    = 1'b0;
            vifs[i].req_addr  = 32'd0;
            vifs[i].req_wdata = 32'd0;
            vifs[i].req_be    = 4'd0;
            vifs[i].rsp_ready = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vifs[i].rsp_valid !== 1'b0 || vifs[i].rsp_rdata !== 32'd0 ||
                vifs[i].rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: valid=%b rdata=%h err=%b, need 0/0/0",
                         i, vifs[i].rsp_valid, vifs[i].rsp_rdata, vifs[i].rsp_err);
            end
        end
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vifs[i].req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready inst%0d: req_ready=%b, need 1", i, vifs[i].req_ready);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er;
        model_access(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, exp_rd, exp_er);
        txn(vifs[1], 1'b1, 32'h20, 32'h1234_5678, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== exp_rd || er !== exp_er) begin
            errors++;
            $display("FAIL basic_store: lat=%0d rdata=%h err=%b, need 2/%h/%b", lat, rd, er,
                     exp_rd, exp_er);
        end
        model_access(1, 1'b0, 32'h20, 32'd0, 4'h0, exp_rd, exp_er);
        txn(vifs[1], 1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== exp_rd || er !== exp_er || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL basic_load: lat=%0d rdata=%h err=%b, need 2/%h/%b", lat, rd, er,
                     exp_rd, exp_er);
        end
    endtask

    task automatic test_byte_enables();
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er;
        model_access(1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, exp_rd, exp_er);
        txn(vifs[1], 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, rd, er);
        model_access(1, 1'b0, 32'h20, 32'd0, 4'hF, exp_rd, exp_er);
        txn(vifs[1], 1'b0, 32'h20, 32'd0, 4'hF, lat, rd, er);
        checks++;
        if (rd !== exp_rd || rd !== 32'h12BB_56DD) begin
            errors++;
            $display("FAIL byte_enable_load: rdata=%h, need %h", rd, exp_rd);
        end
        model_access(1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, exp_rd, exp_er);
        txn(vifs[1], 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'd0) begin
            errors++;
            $display("FAIL be_zero_rsp: lat=%0d rdata=%h, need 2/00000000", lat, rd);
        end
        model_access(1, 1'b0, 32'h20, 32'd0, 4'h0, exp_rd, exp_er);
        txn(vifs[1], 1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL be_zero_unchanged: rdata=%h, need %h", rd, exp_rd);
        end
    endtask

    task automatic test_backpressure();
        virtual dmem_if v;
        logic [31:0] exp_rd, d0;
        logic        exp_er;
        int          n;
        v = vifs[1];
        model_access(1, 1'b0, 32'h20, 32'd0, 4'h0, exp_rd, exp_er);
        v.req_valid = 1'b1;
        v.req_we    = 1'b0;
        v.req_addr  = 32'h20;
        v.req_be    = 4'hF;
        v.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        v.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (v.rsp_valid !== 1'b1 && n < 40);
        d0 = v.rsp_rdata;
        checks++;
        if (n !== 2 || d0 !== exp_rd) begin
            errors++;
            $display("FAIL bp_first: lat=%0d rdata=%h, need 2/%h", n, d0, exp_rd);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (v.rsp_valid !== 1'b1 || v.rsp_rdata !== d0 || v.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b, need 1/%h/0", i,
                         v.rsp_valid, v.rsp_rdata, v.req_ready, d0);
            end
        end
        v.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        v.rsp_ready = 1'b0;
        checks++;
        if (v.req_ready !== 1'b1 || v.rsp_valid !== 1'b0 || v.rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b rdata=%h, need 1/0/00000000",
                     v.req_ready, v.rsp_valid, v.rsp_rdata);
        end
    endtask

    task automatic test_zero_wait_alias();
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic        wes   [3];
        addrs = '{32'h000, 32'h400, 32'h000};
        datas = '{32'hCAFE_F00D, 32'h0000_0055, 32'd0};
        wes   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            model_access(0, wes[i], addrs[i], datas[i], 4'hF, exp_rd, exp_er);
            txn(vifs[0], wes[i], addrs[i], datas[i], 4'hF, lat, rd, er);
            checks++;
            if (lat !== 1 || rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL zero_wait_alias step%0d: lat=%0d rdata=%h err=%b, need 1/%h/%b",
                         i, lat, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er;
        model_access(1, 1'b0, 32'h22, 32'd0, 4'h0, exp_rd, exp_er);
        txn(vifs[1], 1'b0, 32'h22, 32'd0, 4'h0, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== exp_rd || er !== exp_er) begin
            errors++;
            $display("FAIL misalign_load: lat=%0d rdata=%h err=%b, need 2/%h/%b", lat, rd, er,
                     exp_rd, exp_er);
        end
        model_access(1, 1'b1, 32'h23, 32'h0101_0101, 4'hF, exp_rd, exp_er);
        txn(vifs[1], 1'b1, 32'h23, 32'h0101_0101, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'd0 || er !== exp_er) begin
            errors++;
            $display("FAIL misalign_store: lat=%0d rdata=%h err=%b, need 2/00000000/%b", lat,
                     rd, er, exp_er);
        end
        model_access(1, 1'b0, 32'h20, 32'd0, 4'h0, exp_rd, exp_er);
        txn(vifs[1], 1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL misalign_after: rdata=%h, need %h", rd, exp_rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        virtual dmem_if v;
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er; logic seen;
        v = vifs[2];
        model_access(2, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, exp_rd, exp_er);
        txn(v, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, lat, rd, er);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL wait3_latency: lat=%0d, need 4", lat);
        end
        v.req_valid = 1'b1;
        v.req_we    = 1'b1;
        v.req_addr  = 32'h10;
        v.req_wdata = 32'hDEAD_BEEF;
        v.req_be    = 4'hF;
        @(posedge clk);
        #1;
        v.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        #1;
        checks++;
        if (v.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_reset: rsp_valid=%b, need 0", v.rsp_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (v.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || v.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp: saw_valid=%b ready=%b, need 0/1", seen, v.req_ready);
        end
        @(posedge clk);
        #1;
        model_access(2, 1'b0, 32'h10, 32'd0, 4'h0, exp_rd, exp_er);
        txn(v, 1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
        checks++;
        if (rd !== exp_rd || lat !== 4) begin
            errors++;
            $display("FAIL abort_no_write: lat=%0d rdata=%h, need 4/%h", lat, rd, exp_rd);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, exp_rd, a, wd; logic er, exp_er, we; logic [3:0] be;
        for (int inst = 0; inst < 3; inst++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom();
                model_access(inst, 1'b1, 32'(w * 4), wd, 4'hF, exp_rd, exp_er);
                txn(vifs[inst], 1'b1, 32'(w * 4), wd, 4'hF, lat, rd, er);
            end
            for (int k = 0; k < 40; k++) begin
                a = 32'($urandom_range(0, 15)) * 4;
                if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom());
                if ($urandom_range(0, 5) == 0) a[31:10] = 22'($urandom());
                we = 1'($urandom());
                wd = $urandom();
                be = 4'($urandom());
                model_access(inst, we, a, wd, be, exp_rd, exp_er);
                txn(vifs[inst], we, a, wd, be, lat, rd, er);
                checks++;
                if (lat !== wc_of(inst) + 1 || rd !== exp_rd || er !== exp_er) begin
                    errors++;
                    $display("FAIL random inst%0d op%0d we=%b addr=%h: lat=%0d rdata=%h err=%b, need %0d/%h/%b",
                             inst, k, we, a, lat, rd, er, wc_of(inst) + 1, exp_rd, exp_er);
                end
            end
        end
    endtask

    initial begin
        vifs[0] = bus0;
        vifs[1] = bus1;
        vifs[2] = bus3;
        test_reset();
        test_basic();
        test_byte_enables();
        test_backpressure();
        test_zero_wait_alias();
        test_misalign();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
